// File: rtl/keypad_pkg.sv
// Shared types and helpers for the multi-pad matrix keypad scanner.
// Key bits are laid out pad-major, then row, then column.
package keypad_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE
  } scan_state_e;

  function automatic int key_idx(input int p, input int r, input int c,
                                 input int rows, input int cols);
    return p * rows * cols + r * cols + c;
  endfunction

  // Bits needed for a counter that runs 0..n-1 (never narrower than 1)
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Frame-rate debouncer for one key: flips its state after DEB_SCANS
// consecutive evaluated frames disagree with it, pulsing press/release.
module key_debounce
  import keypad_pkg::*;
#(
  parameter int DEB_SCANS = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic upd_i,
  input  logic raw_i,
  output logic key_o,
  output logic press_o,
  output logic release_o
);

  localparam int CW = cnt_w(DEB_SCANS);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_SCANS - 1);

  logic [CW-1:0] cnt_q;
  logic          key_q;
  logic          press_q;
  logic          release_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q     <= '0;
      key_q     <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      if (upd_i) begin
        if (raw_i == key_q) begin
          cnt_q <= '0;
        end else if (cnt_q == CNT_LAST) begin
          key_q     <= raw_i;
          cnt_q     <= '0;
          press_q   <= raw_i;
          release_q <= ~raw_i;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  assign key_o     = key_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: rtl/multi_keypad_scanner.sv
// Lockstep row scanner for NUM_PADS active-low key matrices with per-key
// frame debouncing; keys/press/release/frame outputs are all registered.
module multi_keypad_scanner
  import keypad_pkg::*;
#(
  parameter int NUM_PADS   = 2,
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int SETTLE_CYC = 500,
  parameter int DEB_SCANS  = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         en_i,
  output logic [NUM_PADS*ROWS-1:0]     row_o,
  input  logic [NUM_PADS*COLS-1:0]     col_i,
  output logic [NUM_PADS*ROWS*COLS-1:0] keys_o,
  output logic [NUM_PADS*ROWS*COLS-1:0] press_o,
  output logic [NUM_PADS*ROWS*COLS-1:0] release_o,
  output logic                         frame_o
);

  localparam int K  = NUM_PADS * ROWS * COLS;
  localparam int RW = cnt_w(ROWS);
  localparam int SW = cnt_w(SETTLE_CYC);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);
  localparam logic [RW-1:0] ROW_LAST    = RW'(ROWS - 1);

  logic [NUM_PADS*COLS-1:0] col_meta_q;
  logic [NUM_PADS*COLS-1:0] col_sync_q;
  scan_state_e              state_q;
  logic [RW-1:0]            row_idx_q;
  logic [SW-1:0]            settle_q;
  logic [NUM_PADS*ROWS-1:0] row_q;
  logic [K-1:0]             raw_q;
  logic [K-1:0]             raw_d;
  logic                     frame_q;
  logic                     eval_en;
  logic [K-1:0]             keys;
  logic [K-1:0]             press;
  logic [K-1:0]             rel;

  function automatic logic [NUM_PADS*ROWS-1:0] row_drive(input logic [RW-1:0] idx);
    logic [NUM_PADS*ROWS-1:0] pat;
    pat = '1;
    for (int p = 0; p < NUM_PADS; p++) begin
      for (int r = 0; r < ROWS; r++) begin
        if (RW'(r) == idx) pat[p*ROWS + r] = 1'b0;
      end
    end
    return pat;
  endfunction

  // Released (all ones) is the safe reset value for the column pins
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      col_meta_q <= '1;
      col_sync_q <= '1;
    end else begin
      col_meta_q <= col_i;
      col_sync_q <= col_meta_q;
    end
  end

  // Frame buffer with the currently sampled row merged in, so the last row
  // can be evaluated in the same edge that stores it.
  always_comb begin
    raw_d = raw_q;
    if (state_q == SAMPLE) begin
      for (int p = 0; p < NUM_PADS; p++) begin
        for (int r = 0; r < ROWS; r++) begin
          for (int c = 0; c < COLS; c++) begin
            if (RW'(r) == row_idx_q)
              raw_d[key_idx(p, r, c, ROWS, COLS)] = ~col_sync_q[p*COLS + c];
          end
        end
      end
    end
  end

  assign eval_en = en_i && (state_q == SAMPLE) && (row_idx_q == ROW_LAST);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      row_idx_q <= '0;
      settle_q  <= '0;
      row_q     <= '1;
      raw_q     <= '0;
      frame_q   <= 1'b0;
    end else begin
      frame_q <= eval_en;
      if (!en_i) begin
        state_q   <= IDLE;
        row_idx_q <= '0;
        settle_q  <= '0;
        row_q     <= '1;
      end else begin
        case (state_q)
          IDLE: begin
            state_q   <= SETTLE;
            settle_q  <= '0;
            row_idx_q <= '0;
            row_q     <= row_drive('0);
          end
          SETTLE: begin
            if (settle_q == SETTLE_LAST) begin
              state_q  <= SAMPLE;
              settle_q <= '0;
            end else begin
              settle_q <= settle_q + 1'b1;
            end
          end
          SAMPLE: begin
            raw_q   <= raw_d;
            state_q <= SETTLE;
            if (row_idx_q == ROW_LAST) begin
              row_idx_q <= '0;
              row_q     <= row_drive('0);
            end else begin
              row_idx_q <= row_idx_q + 1'b1;
              row_q     <= row_drive(row_idx_q + 1'b1);
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  for (genvar k = 0; k < K; k++) begin : g_key
    key_debounce #(
      .DEB_SCANS(DEB_SCANS)
    ) u_deb (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .upd_i    (eval_en),
      .raw_i    (raw_d[k]),
      .key_o    (keys[k]),
      .press_o  (press[k]),
      .release_o(rel[k])
    );
  end

  assign row_o     = row_q;
  assign keys_o    = keys;
  assign press_o   = press;
  assign release_o = rel;
  assign frame_o   = frame_q;

endmodule

// File: tb/tb_multi_keypad_scanner.sv
// Self-checking bench: physical matrix model drives the columns, and a
// cycle-position reference model predicts every output each cycle.
module tb_multi_keypad_scanner;

  localparam int NP    = 2;
  localparam int R     = 4;
  localparam int C     = 4;
  localparam int S     = 4;
  localparam int D     = 3;
  localparam int K     = NP * R * C;
  localparam int RP    = S + 1;
  localparam int FRAME = R * RP;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [NP*R-1:0] row_o;
  logic [NP*C-1:0] col;
  logic [K-1:0]  keys_o;
  logic [K-1:0]  press_o;
  logic [K-1:0]  release_o;
  logic          frame_o;

  logic [K-1:0]  phys;

  int tests = 0;
  int fails = 0;
  bit chk_on = 1'b0;
  int cyc = 0;
  int fr_cyc = 0;
  int fr_prev = 0;

  multi_keypad_scanner #(
    .NUM_PADS(NP), .ROWS(R), .COLS(C), .SETTLE_CYC(S), .DEB_SCANS(D)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .en_i     (en),
    .row_o    (row_o),
    .col_i    (col),
    .keys_o   (keys_o),
    .press_o  (press_o),
    .release_o(release_o),
    .frame_o  (frame_o)
  );

  always #5 clk = ~clk;

  // Physical keypad: a pressed key shorts its row line to its column line
  always_comb begin
    col = '1;
    for (int p = 0; p < NP; p++)
      for (int r = 0; r < R; r++)
        for (int c = 0; c < C; c++)
          if (!row_o[p*R + r] && phys[p*R*C + r*C + c]) col[p*C + c] = 1'b0;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: n = number of consecutive enabled edges since idle
  int          n = 0;
  logic [K-1:0] m_keys = '0, m_press = '0, m_rel = '0, m_raw = '0;
  logic [K-1:0] p1 = '0, p2 = '0;
  logic        m_frame = 1'b0;
  logic [NP*R-1:0] m_row = '1;
  int          m_cnt[K];

  function automatic logic [NP*R-1:0] exp_rows(input int cnt);
    logic [NP*R-1:0] v;
    v = '1;
    if (cnt > 0)
      for (int p = 0; p < NP; p++) v[p*R + ((cnt - 1) % FRAME) / RP] = 1'b0;
    return v;
  endfunction

  always @(posedge clk) begin : model
    int pos;
    int rr;
    cyc++;
    m_press = '0;
    m_rel   = '0;
    m_frame = 1'b0;
    if (rst) begin
      n = 0;
      m_keys = '0;
      m_raw  = '0;
      p1 = '0;
      p2 = '0;
      for (int k = 0; k < K; k++) m_cnt[k] = 0;
    end else begin
      if (en) begin
        if (n > 0) begin
          pos = (n - 1) % FRAME;
          if (pos % RP == RP - 1) begin
            rr = pos / RP;
            for (int p = 0; p < NP; p++)
              for (int c = 0; c < C; c++)
                m_raw[p*R*C + rr*C + c] = p2[p*R*C + rr*C + c];
            if (rr == R - 1) begin
              m_frame = 1'b1;
              for (int k = 0; k < K; k++) begin
                if (m_raw[k] == m_keys[k]) m_cnt[k] = 0;
                else if (m_cnt[k] == D - 1) begin
                  m_keys[k] = m_raw[k];
                  m_cnt[k] = 0;
                  if (m_raw[k]) m_press[k] = 1'b1;
                  else m_rel[k] = 1'b1;
                end else m_cnt[k]++;
              end
            end
          end
        end
        n++;
      end else begin
        n = 0;
      end
      p2 = p1;
      p1 = phys;
    end
    m_row = exp_rows(n);
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("row_o", 64'(row_o), 64'(m_row));
      chk("keys_o", 64'(keys_o), 64'(m_keys));
      chk("press_o", 64'(press_o), 64'(m_press));
      chk("release_o", 64'(release_o), 64'(m_rel));
      chk("frame_o", 64'(frame_o), 64'(m_frame));
    end
  end

  task automatic step(input int cnt);
    repeat (cnt) @(posedge clk);
    #2;
  endtask

  task automatic next_frame();
    int b;
    b = 0;
    step(1);
    while (frame_o !== 1'b1 && b < 100) begin
      step(1);
      b++;
    end
    if (frame_o !== 1'b1) chk("frame_wait", 64'(0), 64'(1));
    fr_prev = fr_cyc;
    fr_cyc  = cyc;
  endtask

  initial begin
    int t_en;
    int nfr;
    int off;
    rst  = 1'b1;
    en   = 1'b1;
    phys = '0;
    step(1);
    chk_on = 1'b1;
    step(2);
    chk("rst_row", 64'(row_o), 64'h00FF);
    chk("rst_keys", 64'(keys_o), 64'h0);
    chk("rst_press", 64'(press_o), 64'h0);
    chk("rst_frame", 64'(frame_o), 64'h0);
    rst = 1'b0;
    step(1);
    chk("first_row", 64'(row_o), 64'h00EE);

    // single press of pad0 r1c2
    phys[6] = 1'b1;
    next_frame();
    chk("f1_key6", 64'(keys_o[6]), 64'h0);
    next_frame();
    chk("frame_period", 64'(fr_cyc - fr_prev), 64'd20);
    chk("f2_key6", 64'(keys_o[6]), 64'h0);
    next_frame();
    chk("f3_key6", 64'(keys_o[6]), 64'h1);
    chk("f3_press6", 64'(press_o), 64'h40);
    step(1);
    chk("press6_width", 64'(press_o[6]), 64'h0);

    // release
    phys[6] = 1'b0;
    next_frame();
    next_frame();
    next_frame();
    chk("rel6_pulse", 64'(release_o), 64'h40);
    chk("rel6_key", 64'(keys_o[6]), 64'h0);

    // chord pad0 r1c2 + pad1 r2c3
    phys[6]  = 1'b1;
    phys[27] = 1'b1;
    next_frame();
    next_frame();
    chk("chord_f2", 64'(keys_o), 64'h0);
    next_frame();
    chk("chord_keys", 64'(keys_o), 64'h0800_0040);
    chk("chord_press", 64'(press_o), 64'h0800_0040);
    phys = '0;
    next_frame();
    next_frame();
    next_frame();
    chk("chord_release", 64'(release_o), 64'h0800_0040);
    chk("chord_keys_off", 64'(keys_o), 64'h0);

    // bounce on alternate frames
    for (int i = 0; i < 8; i++) begin
      phys[6] = (i % 2 == 0);
      next_frame();
      chk("bounce_period", 64'(fr_cyc - fr_prev), 64'd20);
      chk("bounce_key6", 64'(keys_o[6]), 64'h0);
      chk("bounce_press6", 64'(press_o[6]), 64'h0);
    end

    // enable drop mid row 2
    phys[6] = 1'b1;
    next_frame();
    next_frame();
    next_frame();
    chk("hold_key6", 64'(keys_o[6]), 64'h1);
    step(12);
    chk("mid_row2", 64'(row_o), 64'h00BB);
    en = 1'b0;
    step(1);
    chk("dis_row", 64'(row_o), 64'h00FF);
    chk("dis_key6", 64'(keys_o[6]), 64'h1);
    phys = '0;
    nfr = 0;
    for (int i = 0; i < 40; i++) begin
      step(1);
      if (frame_o === 1'b1) nfr++;
    end
    chk("dis_no_frame", 64'(nfr), 64'h0);
    chk("dis_keys_held", 64'(keys_o[6]), 64'h1);
    phys[6] = 1'b1;
    en = 1'b1;
    step(1);
    t_en = cyc;
    chk("reen_row0", 64'(row_o), 64'h00EE);
    next_frame();
    chk("reen_latency", 64'(fr_cyc - t_en), 64'd20);

    // reset mid frame while key6 is down
    step(7);
    rst = 1'b1;
    step(1);
    chk("midrst_keys", 64'(keys_o), 64'h0);
    chk("midrst_release", 64'(release_o), 64'h0);
    chk("midrst_row", 64'(row_o), 64'h00FF);
    rst = 1'b0;
    step(1);
    chk("midrst_restart", 64'(row_o), 64'h00EE);

    // randomized traffic
    off = 0;
    for (int i = 0; i < 4000; i++) begin
      if (off > 0) begin
        off--;
        if (off == 0) en = 1'b1;
      end else if ($urandom_range(0, 299) == 0) begin
        en  = 1'b0;
        off = $urandom_range(1, 40);
      end
      if ($urandom_range(0, 39) == 0) phys[$urandom_range(0, K - 1)] ^= 1'b1;
      rst = (i == 2000);
      step(1);
    end
    rst = 1'b0;
    en  = 1'b1;
    step(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
